// File: rtl/rf_pkg.sv
// rf_pkg: shared widths, register count and sequencer states for the register-file write port.
package rf_pkg;
  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int REG_COUNT = 32;
  localparam logic [REG_AW-1:0] ZERO_REG = '0;
  typedef enum logic {CLEAR, RUN} state_t;
endpackage

// File: rtl/rf_write_arbiter_if.sv
// rf_write_arbiter_if: writeback requester handshakes and register-file write port signals.
interface rf_write_arbiter_if #(parameter int DATA_W = 32, parameter int REG_AW = 5);
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [REG_AW-1:0] req0_reg, req1_reg, rf_write_reg;
  logic [DATA_W-1:0] req0_data, req1_data, rf_write_data;
  logic rf_reg_write, rf_reg_dst, init_done;
  modport master (
    output req0_valid, req0_reg, req0_data, req1_valid, req1_reg, req1_data,
    input req0_ready, req1_ready, rf_reg_write, rf_reg_dst, rf_write_reg, rf_write_data, init_done
  );
  modport slave (
    input req0_valid, req0_reg, req0_data, req1_valid, req1_reg, req1_data,
    output req0_ready, req1_ready, rf_reg_write, rf_reg_dst, rf_write_reg, rf_write_data, init_done
  );
endinterface

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant; the priority bit moves to the loser on every accept.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid_i,
  input  logic       en_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o
);
  logic prio_q, prio_d;
  always_comb begin
    gnt_o = !en_i ? 2'b00 : &valid_i ? (prio_q ? 2'b10 : 2'b01) : valid_i;
    prio_d = (accept_i && |gnt_o) ? gnt_o[0] : prio_q;
  end
  always_ff @(posedge clk) begin
    if (rst) prio_q <= 1'b0;
    else prio_q <= prio_d;
  end
endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: clears all registers after reset, then round-robins two writeback requesters onto the write port.
module rf_write_arbiter import rf_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input logic clk,
  input logic rst,
  rf_write_arbiter_if.slave bus
);
  localparam logic [REG_AW-1:0] LAST = REG_AW'(REG_COUNT - 1);
  state_t state_q, state_d;
  logic [REG_AW-1:0] cnt_q, cnt_d, wreg_q, wreg_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic we_q, we_d;
  logic [1:0] gnt;
  logic run;
  assign run = state_q == RUN;
  rr_arbiter2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .valid_i  ({bus.req1_valid, bus.req0_valid}),
    .en_i     (run),
    .accept_i (run),
    .gnt_o    (gnt)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    we_d = 1'b0;
    wreg_d = wreg_q;
    wdata_d = wdata_q;
    if (!run) begin
      we_d = 1'b1;
      wreg_d = cnt_q;
      wdata_d = '0;
      cnt_d = cnt_q + REG_AW'(cnt_q != LAST);
      state_d = cnt_q == LAST ? RUN : CLEAR;
    end else if (|gnt) begin
      wreg_d = gnt[0] ? bus.req0_reg : bus.req1_reg;
      wdata_d = gnt[0] ? bus.req0_data : bus.req1_data;
      // $zero is hardwired after the clear: accept the request but suppress the write
      we_d = wreg_d != REG_AW'(ZERO_REG);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q <= '0;
      we_q <= 1'b0;
      wreg_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      we_q <= we_d;
      wreg_q <= wreg_d;
      wdata_q <= wdata_d;
    end
  end
  assign bus.req0_ready = gnt[0];
  assign bus.req1_ready = gnt[1];
  assign bus.rf_reg_write = we_q;
  assign bus.rf_reg_dst = 1'b1;
  assign bus.rf_write_reg = wreg_q;
  assign bus.rf_write_data = wdata_q;
  assign bus.init_done = run;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: scoreboard bench; each cycle's expected write-port contents are queued and checked a cycle later.
module tb_rf_write_arbiter;
  typedef struct {
    logic we;
    logic full;
    logic [4:0] r;
    logic [31:0] d;
  } wr_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  bit mon_en = 1'b0;
  wr_t q[$];
  wr_t mex;
  rf_write_arbiter_if #(.DATA_W(32), .REG_AW(5)) bus ();
  rf_write_arbiter #(.DATA_W(32), .REG_AW(5)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (mon_en) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL sb_empty: no expected entry for write port");
      end else begin
        mex = q.pop_front();
        if (bus.rf_reg_write !== mex.we || bus.rf_reg_dst !== 1'b1 ||
            ((mex.we || mex.full) && (bus.rf_write_reg !== mex.r || bus.rf_write_data !== mex.d))) begin
          fails++;
          $display("FAIL wport @%0t: got we=%b dst=%b reg=%0d data=%h, want we=%b dst=1 reg=%0d data=%h",
                   $time, bus.rf_reg_write, bus.rf_reg_dst, bus.rf_write_reg, bus.rf_write_data, mex.we, mex.r, mex.d);
        end
      end
    end
  end
  task automatic drive(input logic v0, input logic [4:0] r0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] r1, input logic [31:0] d1);
    bus.req0_valid = v0; bus.req0_reg = r0; bus.req0_data = d0;
    bus.req1_valid = v1; bus.req1_reg = r1; bus.req1_data = d1;
  endtask
  task automatic test_reset();
    drive(1, 5'd3, 32'h1, 1, 5'd4, 32'h2);
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({bus.rf_reg_write, bus.rf_reg_dst, bus.rf_write_reg, bus.rf_write_data, bus.init_done, bus.req0_ready, bus.req1_ready}
        !== {1'b0, 1'b1, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset: got we=%b dst=%b reg=%0d data=%h init=%b rdy=%b%b, want 0 1 0 0 0 00",
               bus.rf_reg_write, bus.rf_reg_dst, bus.rf_write_reg, bus.rf_write_data, bus.init_done, bus.req0_ready, bus.req1_ready);
    end
    @(posedge clk); #1;
    q.push_back('{0, 1, 5'd0, 32'd0});
    mon_en = 1'b1;
    rst = 1'b0;
  endtask
  task automatic test_clear(input logic v);
    bus.req0_valid = v;
    bus.req1_valid = v;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      tests++;
      if ({bus.req0_ready, bus.req1_ready, bus.init_done} !== 3'b000) begin
        fails++;
        $display("FAIL clear_%0d: got rdy=%b%b init=%b, want rdy=00 init=0", k, bus.req0_ready, bus.req1_ready, bus.init_done);
      end
      q.push_back('{1, 1, 5'(k), 32'd0});
      @(posedge clk); #1;
    end
  endtask
  task automatic test_single();
    drive(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0);
    @(negedge clk);
    tests++;
    if ({bus.req0_ready, bus.req1_ready, bus.init_done} !== 3'b101) begin
      fails++;
      $display("FAIL single: got rdy=%b%b init=%b, want rdy=10 init=1", bus.req0_ready, bus.req1_ready, bus.init_done);
    end
    q.push_back('{1, 1, 5'd5, 32'hDEADBEEF});
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    @(negedge clk);
    tests++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
      fails++;
      $display("FAIL idle: got rdy=%b%b, want 00", bus.req0_ready, bus.req1_ready);
    end
    q.push_back('{0, 0, 5'd0, 32'd0});
    @(posedge clk); #1;
  endtask
  task automatic test_reg0();
    drive(0, 5'd0, 32'd0, 1, 5'd0, 32'hFFFFFFFF);
    @(negedge clk);
    tests++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b01) begin
      fails++;
      $display("FAIL reg0: got rdy=%b%b, want 01", bus.req0_ready, bus.req1_ready);
    end
    q.push_back('{0, 0, 5'd0, 32'd0});
    @(posedge clk); #1;
    bus.req1_valid = 1'b0;
  endtask
  task automatic test_contention();
    for (int i = 0; i < 4; i++) begin
      drive(1, 5'd1, (i < 1) ? 32'h11 : 32'h13, 1, 5'd2, (i < 2) ? 32'h22 : 32'h24);
      @(negedge clk);
      tests++;
      if ({bus.req0_ready, bus.req1_ready} !== {i % 2 == 0, i % 2 == 1}) begin
        fails++;
        $display("FAIL contention_%0d: got rdy=%b%b, want %b%b", i, bus.req0_ready, bus.req1_ready, i % 2 == 0, i % 2 == 1);
      end
      if (i % 2 == 0) q.push_back('{1, 1, 5'd1, (i < 1) ? 32'h11 : 32'h13});
      else q.push_back('{1, 1, 5'd2, (i < 2) ? 32'h22 : 32'h24});
      @(posedge clk); #1;
    end
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    @(negedge clk);
    q.push_back('{0, 0, 5'd0, 32'd0});
    @(posedge clk); #1;
  endtask
  task automatic test_reset_mid();
    drive(1, 5'd1, 32'h55, 1, 5'd2, 32'h66);
    @(negedge clk);
    tests++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      fails++;
      $display("FAIL mid_pre: got rdy=%b%b, want 10", bus.req0_ready, bus.req1_ready);
    end
    q.push_back('{1, 1, 5'd1, 32'h55});
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    q.push_back('{0, 1, 5'd0, 32'd0});
    @(posedge clk); #1;
    rst = 1'b0;
    test_clear(1'b1);
    @(negedge clk);
    tests++;
    if ({bus.req0_ready, bus.req1_ready, bus.init_done} !== 3'b101) begin
      fails++;
      $display("FAIL reinit_prio: got rdy=%b%b init=%b, want rdy=10 init=1", bus.req0_ready, bus.req1_ready, bus.init_done);
    end
    q.push_back('{1, 1, 5'd1, 32'h55});
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    @(negedge clk);
    tests++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b01) begin
      fails++;
      $display("FAIL reinit_req1: got rdy=%b%b, want 01", bus.req0_ready, bus.req1_ready);
    end
    q.push_back('{1, 1, 5'd2, 32'h66});
    @(posedge clk); #1;
    bus.req1_valid = 1'b0;
    @(negedge clk);
    q.push_back('{0, 0, 5'd0, 32'd0});
    @(posedge clk); #1;
  endtask
  initial begin
    test_reset();
    test_clear(1'b0);
    test_single();
    test_reg0();
    test_contention();
    test_reset_mid();
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
